// File: rtl/mem_map_pkg.sv
// Shared I/O map for the memory/I/O bridge: window base, register offsets
// and status-register bit positions (also used by the CPU-side tables).
package mem_map_pkg;

    localparam logic [9:0] IO_BASE = 10'h3F0;

    typedef enum logic [3:0] {
        OFF_LED  = 4'd0,
        OFF_SW   = 4'd1,
        OFF_CNT  = 4'd2,
        OFF_TX   = 4'd3,
        OFF_STAT = 4'd4
    } io_off_e;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_MSB = 5;
    localparam int STAT_OVF     = 6;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted pushes only.
    // NOTE: the data array has no reset; only pointers and count define validity,
    // so resetting it would just cost flops/mux logic for no observable effect.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-side memory stage: routes accesses to block RAM or to the I/O window
// at the top of the address space, with a uniform 1-cycle read latency.
module mem_io_bridge #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 16,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] IO_BASE    = mem_map_pkg::IO_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    import mem_map_pkg::*;

    logic                      is_io;
    logic                      io_wr;
    logic [3:0]                io_off;
    logic                      led_wr, cnt_clr, tx_push, stat_wr;
    logic [15:0]               led_q, sw_meta, sw_sync, cnt_q;
    logic                      ovf_q;
    logic                      sel_io_q;
    logic [DATA_W-1:0]         io_rdata_q;
    logic [DATA_W-1:0]         io_mux;
    logic [DATA_W-1:0]         status;
    logic                      fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Address decode: the RAM sees every access, but only RAM-region writes.
    assign is_io     = (cpu_addr >= IO_BASE);
    assign io_off    = 4'(cpu_addr - IO_BASE);
    assign io_wr     = cpu_we & is_io;
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_we & ~is_io;

    assign led_wr  = io_wr && (io_off == OFF_LED);
    assign cnt_clr = io_wr && (io_off == OFF_CNT);
    assign tx_push = io_wr && (io_off == OFF_TX);
    assign stat_wr = io_wr && (io_off == OFF_STAT);

    assign led_out  = led_q;
    assign tx_valid = ~fifo_empty;
    assign fifo_pop = tx_valid & tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (cpu_wdata[7:0]),
        .pop       (fifo_pop),
        .head      (tx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // LED register, switch synchronizer, cycle counter and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (led_wr) led_q <= cpu_wdata[15:0];
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            cnt_q   <= cnt_clr ? 16'h0000 : cnt_q + 16'd1;
            if (stat_wr) begin
                ovf_q <= 1'b0;
            end else if (tx_push && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Status word assembled from live FIFO state.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status = '0;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_FULL]                 = fifo_full;
        status[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(fifo_count);
        status[STAT_OVF]                  = ovf_q;
    end

    // I/O read mux; the counter reads as the value it takes at this edge,
    // so a read one cycle after a clear returns 1.
    always_comb begin
        io_mux = '0;
        case (io_off)
            OFF_LED:  io_mux = led_q;
            OFF_SW:   io_mux = sw_sync;
            OFF_CNT:  io_mux = cnt_q + 16'd1;
            OFF_STAT: io_mux = status;
            default:  io_mux = '0;
        endcase
    end

    // Read-path pipeline register matching the RAM's registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_io_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            sel_io_q   <= is_io;
            io_rdata_q <= io_wr ? cpu_wdata : io_mux;
        end
    end

    assign cpu_rdata = sel_io_q ? io_rdata_q : ram_rdata;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: behavioural RAM, read scoreboard,
// and a byte-queue model of the TX FIFO.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata = 16'h0000;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        we;
        bit          chk;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t         sb_q[$];
    logic [7:0]  tx_q[$];
    vec_t        tbl[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] ram_mem [1024];

    always #5 clk = ~clk;

    mem_io_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    // Synchronous write-through block RAM, not affected by reset.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_rdata         <= ram_wdata;
        end else begin
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One CPU bus cycle; read data is compared one cycle later via the scoreboard.
    task automatic cyc(input logic [9:0] addr, input logic [15:0] wdata, input logic we,
                       input bit chk, input logic [15:0] exp, input string name);
        sb_t e;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_we    = we;
        e.chk = chk; e.exp = exp; e.name = name;
        sb_q.push_back(e);
        #1;
        check({name, "/ram_we"}, {15'h0, ram_we}, {15'h0, (we && (addr < 10'h3F0))});
        if (tx_ready && tx_q.size() != 0) begin
            check({name, "/tx_head"}, {7'h0, tx_valid, tx_data}, {7'h0, 1'b1, tx_q[0]});
            void'(tx_q.pop_front());
        end
        if (we && addr == 10'h3F3 && tx_q.size() < 8) tx_q.push_back(wdata[7:0]);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        if (e.chk) check(e.name, cpu_rdata, e.exp);
    endtask

    task automatic idle();
        cyc(10'h000, 16'h0000, 1'b0, 1'b0, 16'h0000, "idle");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 16'h0000;
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        sw_in = 16'h0000; tx_ready = 1'b0;

        tbl.push_back('{10'h010, 16'h1234, 1'b1, 1'b1, 16'h1234, "ram_wr"});
        tbl.push_back('{10'h010, 16'h0000, 1'b0, 1'b1, 16'h1234, "ram_rd"});
        tbl.push_back('{10'h3EF, 16'h5A5A, 1'b1, 1'b1, 16'h5A5A, "ram_top_wr"});
        tbl.push_back('{10'h3F0, 16'h00A5, 1'b1, 1'b1, 16'h00A5, "led_wr"});
        tbl.push_back('{10'h3EF, 16'h0000, 1'b0, 1'b1, 16'h5A5A, "ram_top_rd"});
        tbl.push_back('{10'h3F0, 16'h0000, 1'b0, 1'b1, 16'h00A5, "led_rd"});
        tbl.push_back('{10'h3F5, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, "unmapped_wr"});
        tbl.push_back('{10'h3F5, 16'h0000, 1'b0, 1'b1, 16'h0000, "unmapped_rd"});
        tbl.push_back('{10'h3FF, 16'h0000, 1'b0, 1'b1, 16'h0000, "last_io_rd"});
        tbl.push_back('{10'h3F0, 16'h0000, 1'b0, 1'b1, 16'h00A5, "led_keep"});
        tbl.push_back('{10'h3F3, 16'h0000, 1'b0, 1'b1, 16'h0000, "tx_rd_zero"});
        tbl.push_back('{10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h0001, "stat_empty"});
        tbl.push_back('{10'h010, 16'h0000, 1'b0, 1'b1, 16'h1234, "ram_rd2"});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", led_out, 16'h0000);
        check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("rst_rdata", cpu_rdata, ram_rdata);
        reset = 1'b0;

        // Table-driven decode / read-path vectors
        foreach (tbl[i]) cyc(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].chk, tbl[i].exp, tbl[i].name);
        check("led_out", led_out, 16'h00A5);

        // Switch synchronizer: visible on the third edge after the change
        sw_in = 16'hBEEF;
        idle();
        idle();
        cyc(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'hBEEF, "sw_rd");

        // FIFO ordering
        tx_ready = 1'b0;
        cyc(10'h3F3, 16'h0041, 1'b1, 1'b0, 16'h0000, "push41");
        cyc(10'h3F3, 16'h0042, 1'b1, 1'b0, 16'h0000, "push42");
        cyc(10'h3F3, 16'h0043, 1'b1, 1'b0, 16'h0000, "push43");
        cyc(10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h000C, "stat_cnt3");
        check("head_hold", {7'h0, tx_valid, tx_data}, 16'h0141);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        check("drain_empty", {15'h0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;
        cyc(10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h0001, "stat_drained");

        // Overflow, sticky clear, push-while-full-with-pop
        for (int i = 0; i < 9; i++) cyc(10'h3F3, 16'h0050 + 16'(i), 1'b1, 1'b0, 16'h0000, "push_ovf");
        cyc(10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h0062, "stat_ovf");
        cyc(10'h3F4, 16'h0000, 1'b1, 1'b1, 16'h0000, "stat_clr_wr");
        cyc(10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h0022, "stat_full");
        tx_ready = 1'b1;
        cyc(10'h3F3, 16'h0059, 1'b1, 1'b1, 16'h0059, "push_full_pop");
        tx_ready = 1'b0;
        cyc(10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h0022, "stat_still_full");
        tx_ready = 1'b1;
        for (int i = 0; i < 16 && tx_q.size() != 0; i++) idle();
        check("ovf_drain_len", 16'(tx_q.size()), 16'h0000);
        check("ovf_drain_empty", {15'h0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // Cycle counter: clear, read-after-clear, full wrap
        cyc(10'h3F2, 16'h0000, 1'b1, 1'b1, 16'h0000, "cnt_clr");
        cyc(10'h3F2, 16'h0000, 1'b0, 1'b1, 16'h0001, "cnt_rd1");
        cyc(10'h3F2, 16'h0000, 1'b0, 1'b1, 16'h0002, "cnt_rd2");
        cyc(10'h3F2, 16'h0000, 1'b1, 1'b1, 16'h0000, "cnt_clr2");
        cpu_we = 1'b0; cpu_addr = 10'h000;
        repeat (65535) @(posedge clk);
        #1;
        cyc(10'h3F2, 16'h0000, 1'b0, 1'b1, 16'h0000, "cnt_wrap");

        // Asynchronous reset in the middle of a drain
        cyc(10'h020, 16'hCAFE, 1'b1, 1'b1, 16'hCAFE, "ram_pre_rst");
        cyc(10'h3F0, 16'h00FF, 1'b1, 1'b1, 16'h00FF, "led_pre_rst");
        for (int i = 0; i < 4; i++) cyc(10'h3F3, 16'h0061 + 16'(i), 1'b1, 1'b0, 16'h0000, "push_rst");
        tx_ready = 1'b1;
        cyc(10'h020, 16'h0000, 1'b0, 1'b1, 16'hCAFE, "ram_rd_drain");
        cyc(10'h3F0, 16'h0000, 1'b0, 1'b1, 16'h00FF, "led_rd_drain");
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("mid_rst_led", led_out, 16'h0000);
        check("mid_rst_rdata", cpu_rdata, ram_rdata);
        tx_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc(10'h3F4, 16'h0000, 1'b0, 1'b1, 16'h0001, "post_rst_stat");
        cyc(10'h020, 16'h0000, 1'b0, 1'b1, 16'hCAFE, "post_rst_ram");
        cyc(10'h3F0, 16'h0000, 1'b0, 1'b1, 16'h0000, "post_rst_led");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Memory-side stage directly downstream of the CPU bus (addr/data_in/write_en/data_out). Decodes every CPU access: the low region goes to the 1024x16 synchronous block RAM, the top 16 words to memory-mapped I/O registers. I/O covers LEDs, synchronized switches, a free-running cycle counter and a byte TX FIFO with a valid/ready handshake toward a serial transmitter. The CPU sees one uniform 1-cycle read latency, identical to bare RAM.

Parameters:
ADDR_W, 10, CPU/RAM word-address width
DATA_W, 16, data width
FIFO_DEPTH, 8, TX FIFO entries (power of two)
IO_BASE, 10'h3F0, first I/O address; the I/O window is IO_BASE..IO_BASE+15

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_we  in  1  CPU write enable
cpu_rdata  out  DATA_W  read data to CPU, valid the cycle after the address
ram_addr  out  ADDR_W  to RAM, equal to cpu_addr
ram_wdata  out  DATA_W  to RAM, equal to cpu_wdata
ram_we  out  1  RAM write enable, gated by the RAM-region decode
ram_rdata  in  DATA_W  RAM read data, registered in the RAM
sw_in  in  16  asynchronous board switches
led_out  out  16  LED register
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO not empty
tx_ready  in  1  consumer accepts tx_data this cycle

Behaviour:
- Decode: is_io = (cpu_addr >= IO_BASE). ram_we = cpu_we & ~is_io. RAM writes through and reads normally for all RAM addresses.
- Read path: sel_io_q <= is_io and io_rdata_q <= io mux, both at every posedge. cpu_rdata = sel_io_q ? io_rdata_q : ram_rdata. Latency is exactly 1 cycle for both regions.
- I/O write-through: when an I/O write occurs, io_rdata_q <= cpu_wdata. This matches the RAM write-through.
- I/O map (offset from IO_BASE):
  - 0: LED, R/W.
  - 1: switches, RO, 2-flop synchronized.
  - 2: cycle counter, R; any write clears it. The counter is 16-bit, increments every cycle, and wraps FFFF->0000.
  - 3: TX data, WO; a write pushes cpu_wdata[7:0]; reads return 0.
  - 4: status, R. Bit0 = empty, bit1 = full, bits[5:2] = count (0..8), bit6 = overflow sticky. Any write clears bit6.
  - 5..15: unmapped; reads return 0, writes are ignored.
- Reads never have side effects. Reading offset 3 does not pop the FIFO.
- Counter clear priority: a write to offset 2 in cycle N makes the counter 0 after edge N. It reads 1 one cycle later.
- FIFO rules:
  - tx_valid = (count != 0); tx_data = head entry.
  - Pop when tx_valid & tx_ready.
  - A push when not full is accepted.
  - A push when full with a simultaneous pop is accepted: order is preserved and count is unchanged.
  - A push when full without a pop is dropped, and bit6 is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
- Reset (async, any time, including mid-drain):
  - led_out=0, counter=0, FIFO empty (tx_valid=0), overflow=0.
  - Sync flops=0, sel_io_q=0, io_rdata_q=0.
  - cpu_rdata therefore shows ram_rdata after reset.
  - RAM contents are untouched.

Decomposition:
- Package mem_map_pkg holds:
  - IO_BASE;
  - offset constants OFF_LED, OFF_SW, OFF_CNT, OFF_TX, OFF_STAT;
  - status bit indices.
  The CPU-side assembler tables share the same constants.
- Sub-module sync_fifo (params WIDTH=8, DEPTH) provides:
  - ports: push, push_data, pop, head, count, full, empty;
  - asynchronous active-high reset.
- mem_io_bridge contains the decode, the registers and the read mux.

Test Plan:
- RAM pass-through: write 0x1234 to addr 0x010, then read 0x010 → cpu_rdata=0x1234 one cycle after the read. Writing to 0x3F0 never asserts ram_we.
- LED/switch: write 0x00A5 to 0x3F0 → led_out=0x00A5, and a read of 0x3F0 returns 0x00A5. Set sw_in=0xBEEF → a read of 0x3F1 returns 0xBEEF within 3 cycles.
- FIFO order: with tx_ready=0, push 0x41, 0x42, 0x43 → status reads count=3, empty=0. Raise tx_ready → tx_data is 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0 and status bit0=1.
- Overflow: tx_ready=0, push 9 bytes → status=full, count=8, bit6=1, and the 9th byte is absent from the drain. Write to 0x3F4 → bit6=0. Push while full with tx_ready=1 → accepted, count stays 8.
- Counter: write 0 to 0x3F2, then read 0x3F2 on the next cycle → value 1. Preload by running 65536 cycles → wraps to 0.
- Reset mid-drain: 4 bytes queued, tx_ready=1, assert reset mid-cycle → tx_valid=0 and led_out=0 immediately (asynchronous). After release, status reads 0x0001 and RAM data written before reset reads back unchanged.
